// File: rtl/uart_param_txrx.sv
// Full-duplex UART, LSB first, optional even/odd parity, 1-2 stop bits; TX and RX run independently.
// TX accepts tx_start only when idle, with no backpressure. RX pulses rx_valid one cycle after the last stop-bit sample.
module uart_param_txrx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              txd,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [2:0]        tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_done_q, tx_done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_done_d  = 1'b0;
    if (tx_state_q == S_IDLE) begin
      if (tx_start) begin
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_sh_d    = tx_data;
        tx_par_d   = (PARITY == 2) ? ~^tx_data : ^tx_data;
      end
    end else if (tx_cnt_q != BIT_END) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        S_START: tx_state_d = S_DATA;
        S_DATA: begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: tx_state_d = S_STOP;
        default: begin
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == LAST_STOP) begin
            tx_state_d = S_IDLE;
            tx_done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    case (tx_state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = tx_sh_q[0];
      S_PARITY: txd = tx_par_q;
      default:  txd = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state_q != S_IDLE);
  assign tx_done = tx_done_q;

  logic              rx_s1_q, rx_s2_q;
  logic [2:0]        rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_pacc_q, rx_pacc_d, rx_facc_q, rx_facc_d, rx_fe_now;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pacc_d  = rx_pacc_q;
    rx_facc_d  = rx_facc_q;
    rx_fe_now  = rx_facc_q | ~rx_s2_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      // Half a bit into the start bit: a high line here means it was a glitch.
      S_START: begin
        if (rx_cnt_q != HALF_END) begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_pacc_d  = 1'b0;
          rx_facc_d  = 1'b0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_WAIT: begin
        if (rx_s2_q) rx_state_d = S_IDLE;
      end
      default: begin
        if (rx_cnt_q != BIT_END) begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else begin
          rx_cnt_d = '0;
          case (rx_state_q)
            S_DATA: begin
              rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
              rx_bit_d = rx_bit_q + 4'd1;
              if (rx_bit_q == LAST_DATA) begin
                rx_bit_d   = '0;
                rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: begin
              rx_pacc_d  = rx_s2_q ^ ((PARITY == 2) ? ~^rx_sh_q : ^rx_sh_q);
              rx_state_d = S_STOP;
            end
            default: begin
              rx_facc_d = rx_fe_now;
              rx_bit_d  = rx_bit_q + 4'd1;
              if (rx_bit_q == LAST_STOP) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
                rx_perr_d  = rx_pacc_q;
                rx_ferr_d  = rx_fe_now;
                rx_state_d = rx_fe_now ? S_WAIT : S_IDLE;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pacc_q  <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pacc_q  <= rx_pacc_d;
      rx_facc_q  <= rx_facc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_param_txrx.sv
// Two UART instances: A (8 bits, even parity, 1 stop) and B (7 bits, odd parity, 2 stops), scoreboard-checked.
`timescale 1ns/1ps
module tb_uart_param_txrx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_start, a_busy, a_done, a_txd, a_rxd, a_rv, a_pe, a_fe, lb_a, rxd_drv;
  logic [7:0] a_tdata, a_rdata;
  logic       b_start, b_busy, b_done, b_txd, b_rv, b_pe, b_fe;
  logic [6:0] b_tdata, b_rdata;

  assign a_rxd = lb_a ? a_txd : rxd_drv;

  uart_param_txrx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_start(a_start), .tx_data(a_tdata), .tx_busy(a_busy),
    .tx_done(a_done), .txd(a_txd), .rxd(a_rxd), .rx_data(a_rdata), .rx_valid(a_rv),
    .rx_parity_err(a_pe), .rx_frame_err(a_fe));

  uart_param_txrx #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(b_start), .tx_data(b_tdata), .tx_busy(b_busy),
    .tx_done(b_done), .txd(b_txd), .rxd(b_txd), .rx_data(b_rdata), .rx_valid(b_rv),
    .rx_parity_err(b_pe), .rx_frame_err(b_fe));

  typedef struct { logic [15:0] bits; int n; } frame_t;
  typedef struct { int d; int pe; int fe; } rx_t;

  frame_t txq_a[$], txq_b[$];
  rx_t    rxq_a[$], rxq_b[$];
  int n_chk = 0, n_pass = 0;
  int done_a = 0, done_b = 0, exp_done_a = 0, exp_done_b = 0;
  int hold_a = 0, hold_b = 0, rxv_a = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Serial line image of one frame, one entry per bit period.
  function automatic frame_t mk_frame(int d, int dw, int par, int stops);
    frame_t f;
    int ones;
    f.bits = '1;
    f.bits[0] = 1'b0;
    f.n = 1;
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      f.bits[f.n] = 1'((d >> i) & 1);
      ones += (d >> i) & 1;
      f.n++;
    end
    if (par != 0) begin
      f.bits[f.n] = (par == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
      f.n++;
    end
    f.n += stops;
    return f;
  endfunction

  task automatic send_a(int d, bit loop);
    int t = 0;
    while (a_busy && t < 1000) begin @(posedge clk); #1; t++; end
    chk("sendA_wait_idle", int'(a_busy), 0);
    a_start = 1'b1;
    a_tdata = 8'(d);
    txq_a.push_back(mk_frame(d, 8, 1, 1));
    exp_done_a++;
    if (loop) rxq_a.push_back('{d, 0, 0});
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic send_b(int d);
    int t = 0;
    while (b_busy && t < 1000) begin @(posedge clk); #1; t++; end
    chk("sendB_wait_idle", int'(b_busy), 0);
    b_start = 1'b1;
    b_tdata = 7'(d);
    txq_b.push_back(mk_frame(d, 7, 2, 2));
    exp_done_b++;
    rxq_b.push_back('{d, 0, 0});
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic drive_rx(int d, int flip, int stopv, int low_extra);
    frame_t f;
    f = mk_frame(d, 8, 1, 1);
    f.bits[9]  = f.bits[9] ^ 1'(flip);
    f.bits[10] = 1'(stopv);
    rxq_a.push_back('{d, flip, (stopv == 0) ? 1 : 0});
    for (int k = 0; k < f.n * CPB; k++) begin
      rxd_drv = f.bits[k / CPB];
      @(posedge clk); #1;
    end
    if (low_extra > 0) begin
      rxd_drv = 1'b0;
      repeat (low_extra) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((a_busy || b_busy || rxq_a.size() != 0 || rxq_b.size() != 0) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_in_time", int'(t < 5000), 1);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && a_done) done_a++;
    if (!rst && b_done) done_b++;
  end

  initial begin : txmon_a
    frame_t fr;
    int bad;
    bit pb, ab;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (a_busy === 1'b1 && !pb && !rst) begin
        chk("txA_expected", int'(txq_a.size() > 0), 1);
        if (txq_a.size() > 0) begin
          fr = txq_a.pop_front();
          bad = 0;
          ab = 1'b0;
          for (int k = 0; k < fr.n * CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin ab = 1'b1; break; end
            if (a_txd !== fr.bits[k / CPB] || a_busy !== 1'b1 || a_done !== 1'b0) bad++;
          end
          if (!ab) begin
            chk("txA_frame_bits", bad, 0);
            @(negedge clk);
            chk("txA_done_pulse", int'(a_done), 1);
            chk("txA_busy_at_done", int'(a_busy), 0);
          end
        end
      end
      pb = (a_busy === 1'b1);
    end
  end

  initial begin : txmon_b
    frame_t fr;
    int bad;
    bit pb, ab;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (b_busy === 1'b1 && !pb && !rst) begin
        chk("txB_expected", int'(txq_b.size() > 0), 1);
        if (txq_b.size() > 0) begin
          fr = txq_b.pop_front();
          bad = 0;
          ab = 1'b0;
          for (int k = 0; k < fr.n * CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin ab = 1'b1; break; end
            if (b_txd !== fr.bits[k / CPB] || b_busy !== 1'b1 || b_done !== 1'b0) bad++;
          end
          if (!ab) begin
            chk("txB_frame_bits", bad, 0);
            @(negedge clk);
            chk("txB_done_pulse", int'(b_done), 1);
            chk("txB_busy_at_done", int'(b_busy), 0);
          end
        end
      end
      pb = (b_busy === 1'b1);
    end
  end

  initial begin : rxmon_a
    rx_t e, last;
    last = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '{0, 0, 0};
      end else if (a_rv) begin
        rxv_a++;
        chk("rxA_expected", int'(rxq_a.size() > 0), 1);
        if (rxq_a.size() > 0) begin
          e = rxq_a.pop_front();
          chk("rxA_data", int'(a_rdata), e.d);
          chk("rxA_parity_err", int'(a_pe), e.pe);
          chk("rxA_frame_err", int'(a_fe), e.fe);
        end
        last = '{int'(a_rdata), int'(a_pe), int'(a_fe)};
      end else if (int'(a_rdata) != last.d || int'(a_pe) != last.pe || int'(a_fe) != last.fe) begin
        hold_a++;
      end
    end
  end

  initial begin : rxmon_b
    rx_t e, last;
    last = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '{0, 0, 0};
      end else if (b_rv) begin
        chk("rxB_expected", int'(rxq_b.size() > 0), 1);
        if (rxq_b.size() > 0) begin
          e = rxq_b.pop_front();
          chk("rxB_data", int'(b_rdata), e.d);
          chk("rxB_parity_err", int'(b_pe), e.pe);
          chk("rxB_frame_err", int'(b_fe), e.fe);
        end
        last = '{int'(b_rdata), int'(b_pe), int'(b_fe)};
      end else if (int'(b_rdata) != last.d || int'(b_pe) != last.pe || int'(b_fe) != last.fe) begin
        hold_b++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int snap_rx, snap_done, d;
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_tdata = '0; b_tdata = '0;
    lb_a = 1'b1; rxd_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_txd", int'(a_txd), 1);
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_a_rx_valid", int'(a_rv), 0);
    chk("rst_a_rx_data", int'(a_rdata), 0);
    chk("rst_a_errs", int'({a_pe, a_fe}), 0);
    chk("rst_b_txd", int'(b_txd), 1);
    chk("rst_b_rx_data", int'(b_rdata), 0);
    @(posedge clk); #1;

    fork
      send_a(8'h81, 1'b1);
      send_b(7'h55);
    join
    fork
      for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 6; i++) send_b(int'($urandom_range(0, 127)));
    join
    wait_idle();

    // start requests while busy must not disturb the frame in flight
    d = int'($urandom_range(0, 255));
    send_a(d, 1'b1);
    repeat (20) @(posedge clk);
    #1 a_start = 1'b1; a_tdata = 8'(~d);
    repeat (3) @(posedge clk);
    #1 a_start = 1'b0;
    wait_idle();

    lb_a = 1'b0;
    fork
      drive_rx(8'hA5, 1, 1, 0);
      send_a(int'($urandom_range(0, 255)), 1'b0);
    join
    drive_rx(int'($urandom_range(0, 255)), 0, 1, 0);
    drive_rx(8'h3C, 0, 0, 40);
    drive_rx(int'($urandom_range(0, 255)), 0, 1, 0);
    wait_idle();

    snap_rx = rxv_a;
    rxd_drv = 1'b0;
    repeat (CPB / 2 - 2) @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("glitch_no_rx_valid", rxv_a, snap_rx);
    drive_rx(int'($urandom_range(0, 255)), 0, 1, 0);
    wait_idle();

    lb_a = 1'b1;
    send_a(int'($urandom_range(0, 255)), 1'b1);
    repeat (4 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    rxq_a.delete();
    exp_done_a--;
    snap_rx = rxv_a;
    snap_done = done_a;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_txd", int'(a_txd), 1);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_done", int'(a_done), 0);
    chk("midrst_rx_valid", int'(a_rv), 0);
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("midrst_no_late_rx", rxv_a, snap_rx);
    chk("midrst_no_late_done", done_a, snap_done);
    send_a(8'hFF, 1'b1);
    wait_idle();

    chk("txA_queue_empty", txq_a.size(), 0);
    chk("txB_queue_empty", txq_b.size(), 0);
    chk("txA_done_count", done_a, exp_done_a);
    chk("txB_done_count", done_b, exp_done_b);
    chk("rxA_outputs_held", hold_a, 0);
    chk("rxB_outputs_held", hold_b, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
